// File: rtl/mmp_modexp_pkg.sv
// Shared encodings for the modular-exponentiation sequencer: operand sources,
// result destinations, FSM states and the per-state multiplier select lookup.
package mmp_modexp_pkg;

    localparam logic [2:0] SRC_BASE = 3'd0;
    localparam logic [2:0] SRC_R2   = 3'd1;
    localparam logic [2:0] SRC_ONE  = 3'd2;
    localparam logic [2:0] SRC_ACC  = 3'd3;
    localparam logic [2:0] SRC_XM   = 3'd4;

    localparam logic [1:0] DST_XM     = 2'd0;
    localparam logic [1:0] DST_ACC    = 2'd1;
    localparam logic [1:0] DST_RESULT = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE_X,
        ST_PRE_A,
        ST_FETCH,
        ST_FWAIT,
        ST_SQR,
        ST_MUL,
        ST_POST,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] dst;
    } op_sel_t;

    // Non-multiply states park the selects at zero.
    function automatic op_sel_t op_sel(state_e st);
        op_sel_t s;
        s = '0;
        case (st)
            ST_PRE_X: s = '{x: SRC_BASE, y: SRC_R2,  dst: DST_XM};
            ST_PRE_A: s = '{x: SRC_ONE,  y: SRC_R2,  dst: DST_ACC};
            ST_SQR:   s = '{x: SRC_ACC,  y: SRC_ACC, dst: DST_ACC};
            ST_MUL:   s = '{x: SRC_ACC,  y: SRC_XM,  dst: DST_ACC};
            ST_POST:  s = '{x: SRC_ACC,  y: SRC_ONE, dst: DST_RESULT};
            default:  s = '0;
        endcase
        return s;
    endfunction

    function automatic logic is_mm_state(state_e st);
        return (st == ST_PRE_X) || (st == ST_PRE_A) || (st == ST_SQR) ||
               (st == ST_MUL)   || (st == ST_POST);
    endfunction

endpackage

// File: rtl/mmp_modexp_if.sv
// Multiplier handshake and exponent-memory read port between the sequencer
// (master) and the multiplier core with its operand/exponent RAMs (slave).
interface mmp_modexp_if #(
    parameter int N      = 32,
    parameter int K      = 128,
    parameter int ADDR_W = $clog2(N)
) ();

    logic              mm_req;
    logic              mm_end;
    logic [2:0]        mm_x_sel;
    logic [2:0]        mm_y_sel;
    logic [1:0]        mm_dst_sel;
    logic [ADDR_W-1:0] exp_rd_addr;
    logic [K-1:0]      exp_rd_data;

    modport master (
        output mm_req, mm_x_sel, mm_y_sel, mm_dst_sel, exp_rd_addr,
        input  mm_end, exp_rd_data
    );

    modport slave (
        input  mm_req, mm_x_sel, mm_y_sel, mm_dst_sel, exp_rd_addr,
        output mm_end, exp_rd_data
    );

endinterface

// File: rtl/mmp_modexp_ebit.sv
// Exponent bit streamer: remaining-bit counter, word address, MSB-aligned
// shift register and the flags the sequencer needs to walk bits MSB first.
module mmp_modexp_ebit
    import mmp_modexp_pkg::*;
#(
    parameter int N      = 32,
    parameter int K      = 128,
    parameter int ADDR_W = $clog2(N),
    parameter int LEN_W  = $clog2(N*K) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LEN_W-1:0]  exp_len,
    input  logic              fetch,
    input  logic              word_load,
    input  logic              step,
    input  logic [K-1:0]      rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              cur_bit,
    output logic              zero,
    output logic              last,
    output logic              wrap
);

    localparam int                KW      = $clog2(K);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(N * K);

    logic [LEN_W-1:0]  b_q, b_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [K-1:0]      shreg_q, shreg_d;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_next;
    logic [KW-1:0]     shamt;

    assign idx      = b_q - LEN_W'(1);
    assign idx_next = b_d - LEN_W'(1);
    // Shifting left by (K-1 - i%K) puts the current bit at the MSB.
    assign shamt    = KW'(K - 1) - KW'(idx);

    always_comb begin
        b_d     = b_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        if (load) begin
            b_d     = (exp_len > MAX_LEN) ? MAX_LEN : exp_len;
            addr_d  = '0;
            shreg_d = '0;
        end else begin
            if (step) begin
                b_d     = b_q - LEN_W'(1);
                shreg_d = shreg_q << 1;
            end
            if (word_load) begin
                shreg_d = rd_data << shamt;
            end
            if (fetch) begin
                addr_d = ADDR_W'(idx_next >> KW);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q     <= '0;
            addr_q  <= '0;
            shreg_q <= '0;
        end else begin
            b_q     <= b_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
        end
    end

    assign rd_addr = addr_q;
    assign cur_bit = shreg_q[K-1];
    assign zero    = (b_q == '0);
    assign last    = (b_q == LEN_W'(1));
    // Bit index 0 of a word is the last one before the next (lower) word.
    assign wrap    = (KW'(idx) == '0);

endmodule

// File: rtl/mmp_modexp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving a single
// Montgomery multiplier over a level-request / pulse-done handshake.
module mmp_modexp_ctrl
    import mmp_modexp_pkg::*;
#(
    parameter int N      = 32,
    parameter int K      = 128,
    parameter int ADDR_W = $clog2(N),
    parameter int LEN_W  = $clog2(N*K) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             task_req,
    input  logic [LEN_W-1:0] exp_len,
    output logic             busy,
    output logic             task_end,
    mmp_modexp_if.master     mm_bus
);

    state_e   state_q, state_d;
    logic     mm_req_q, mm_req_d;
    logic     busy_q, busy_d;
    logic     task_end_q, task_end_d;
    op_sel_t  sel_q, sel_d;

    logic     advance;
    logic     bit_done;
    logic     load, fetch, word_load, step;
    logic     cur_bit, zero, last, wrap;

    logic [ADDR_W-1:0] rd_addr;

    mmp_modexp_ebit #(
        .N      (N),
        .K      (K),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_ebit (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .exp_len   (exp_len),
        .fetch     (fetch),
        .word_load (word_load),
        .step      (step),
        .rd_data   (mm_bus.exp_rd_data),
        .rd_addr   (rd_addr),
        .cur_bit   (cur_bit),
        .zero      (zero),
        .last      (last),
        .wrap      (wrap)
    );

    // A done pulse only counts while a request is actually outstanding.
    assign advance = mm_req_q & mm_bus.mm_end;

    always_comb begin
        state_d    = state_q;
        mm_req_d   = mm_req_q;
        busy_d     = busy_q;
        task_end_d = 1'b0;
        load       = 1'b0;
        fetch      = 1'b0;
        word_load  = 1'b0;
        step       = 1'b0;
        bit_done   = 1'b0;

        if (advance) begin
            mm_req_d = 1'b0;
        end else if (is_mm_state(state_q) && !mm_req_q) begin
            mm_req_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (task_req) begin
                    state_d  = ST_PRE_X;
                    mm_req_d = 1'b1;
                    busy_d   = 1'b1;
                    load     = 1'b1;
                end
            end
            ST_PRE_X: begin
                if (advance) state_d = ST_PRE_A;
            end
            ST_PRE_A: begin
                if (advance) begin
                    if (zero) begin
                        state_d = ST_POST;
                    end else begin
                        state_d = ST_FETCH;
                        fetch   = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_FWAIT;
            end
            ST_FWAIT: begin
                word_load = 1'b1;
                state_d   = ST_SQR;
                mm_req_d  = 1'b1;
            end
            ST_SQR: begin
                if (advance) begin
                    if (cur_bit) state_d = ST_MUL;
                    else         bit_done = 1'b1;
                end
            end
            ST_MUL: begin
                if (advance) bit_done = 1'b1;
            end
            ST_POST: begin
                if (advance) begin
                    state_d    = ST_DONE;
                    task_end_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retire the current bit and pick the next step of the bit loop.
        if (bit_done) begin
            step = 1'b1;
            if (last) begin
                state_d = ST_POST;
            end else if (wrap) begin
                state_d = ST_FETCH;
                fetch   = 1'b1;
            end else begin
                state_d = ST_SQR;
            end
        end

        sel_d = op_sel(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mm_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            task_end_q <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            mm_req_q   <= mm_req_d;
            busy_q     <= busy_d;
            task_end_q <= task_end_d;
            sel_q      <= sel_d;
        end
    end

    assign busy               = busy_q;
    assign task_end           = task_end_q;
    assign mm_bus.mm_req      = mm_req_q;
    assign mm_bus.mm_x_sel    = sel_q.x;
    assign mm_bus.mm_y_sel    = sel_q.y;
    assign mm_bus.mm_dst_sel  = sel_q.dst;
    assign mm_bus.exp_rd_addr = rd_addr;

endmodule

// File: tb/tb_mmp_modexp_ctrl.sv
// Scoreboard bench for mmp_modexp_ctrl: expected multiply sequences come from a
// square-and-multiply reference over the exponent memory; a monitor checks ops.
module tb_mmp_modexp_ctrl;

    localparam int N      = 32;
    localparam int K      = 128;
    localparam int ADDR_W = $clog2(N);
    localparam int LEN_W  = $clog2(N*K) + 1;

    localparam int BASE = 0, R2 = 1, ONE = 2, ACC = 3, XM = 4;
    localparam int D_XM = 0, D_ACC = 1, D_RES = 2;

    typedef struct {
        int x;
        int y;
        int dst;
        int addr;
        bit chk_addr;
        int gap;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             task_req;
    logic [LEN_W-1:0] exp_len;
    logic             busy;
    logic             task_end;

    logic [K-1:0] mem [N];

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   max_lat = 0;
    bit   spurious_en = 0;
    bit   task_pending = 0;
    int   task_end_cnt = 0;

    mmp_modexp_if #(.N(N), .K(K)) bus ();

    mmp_modexp_ctrl #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .task_req (task_req),
        .exp_len  (exp_len),
        .busy     (busy),
        .task_end (task_end),
        .mm_bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus.exp_rd_data <= mem[bus.exp_rd_addr];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Multiplier model: random completion latency, optional stray done pulses.
    initial begin
        bit pending;
        int cnt;
        pending = 0;
        cnt = 0;
        bus.mm_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mm_end = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else if (bus.mm_req) begin
                if (!pending) begin
                    pending = 1;
                    cnt = $urandom_range(0, max_lat);
                end
                if (cnt == 0) begin
                    bus.mm_end = 1'b1;
                    pending = 0;
                end else begin
                    cnt--;
                end
            end else begin
                pending = 0;
                if (spurious_en && $urandom_range(0, 2) == 0) bus.mm_end = 1'b1;
            end
        end
    end

    // Monitor: pops one expectation per mm_req rise; tracks gaps and stability.
    bit prev_req = 0;
    bit stab_bad = 0;
    bit post_ended = 0;
    int low_cnt = 0;
    int cur_x = 0, cur_y = 0, cur_dst = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   = 0;
            stab_bad   = 0;
            post_ended = 0;
            low_cnt    = 0;
        end else begin
            if (post_ended) begin
                checkOutput("task_end_after_post", int'(task_end), 1);
                post_ended = 0;
            end
            if (bus.mm_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_op", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("x_sel", int'(bus.mm_x_sel), e.x);
                    checkOutput("y_sel", int'(bus.mm_y_sel), e.y);
                    checkOutput("dst_sel", int'(bus.mm_dst_sel), e.dst);
                    if (e.chk_addr) checkOutput("exp_rd_addr", int'(bus.exp_rd_addr), e.addr);
                    if (e.gap >= 0) checkOutput("req_gap", low_cnt, e.gap);
                    checkOutput("busy_during_op", int'(busy), 1);
                end
                cur_x    = int'(bus.mm_x_sel);
                cur_y    = int'(bus.mm_y_sel);
                cur_dst  = int'(bus.mm_dst_sel);
                stab_bad = 0;
            end
            if (bus.mm_req && (int'(bus.mm_x_sel) != cur_x || int'(bus.mm_y_sel) != cur_y ||
                               int'(bus.mm_dst_sel) != cur_dst))
                stab_bad = 1;
            if (bus.mm_req && bus.mm_end) begin
                checkOutput("sel_stable", int'(stab_bad), 0);
                if (cur_dst == D_RES) post_ended = 1;
                low_cnt = 0;
            end else if (!bus.mm_req) begin
                low_cnt++;
            end
            if (task_end) begin
                checkOutput("busy_at_task_end", int'(busy), 0);
                checkOutput("ops_left_at_end", exp_q.size(), 0);
                checkOutput("task_end_expected", int'(task_pending), 1);
                task_pending = 0;
                task_end_cnt++;
            end
            prev_req = bus.mm_req;
        end
    end

    task automatic pushOp(input int x, input int y, input int dst, input int addr,
                          input bit chk, input int gap);
        exp_t e;
        e.x = x; e.y = y; e.dst = dst; e.addr = addr; e.chk_addr = chk; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Builds the expected op list from the exponent bits, then launches the task.
    task automatic applyStimulus(input int len_in, input int lat, input bit dup_req,
                                 input bit spur, input bit wait_done);
        int len;
        int start_cnt;
        int nops;
        int bound;
        len = (len_in > N*K) ? N*K : len_in;
        pushOp(BASE, R2, D_XM, 0, 0, -1);
        pushOp(ONE, R2, D_ACC, 0, 0, 1);
        for (int i = len - 1; i >= 0; i--) begin
            logic [K-1:0] w;
            w = mem[i / K];
            pushOp(ACC, ACC, D_ACC, i / K, 1, (i == len - 1 || i % K == K - 1) ? 2 : 1);
            if (w[i % K]) pushOp(ACC, XM, D_ACC, i / K, 1, 1);
        end
        pushOp(ACC, ONE, D_RES, 0, 0, 1);
        nops         = exp_q.size();
        max_lat      = lat;
        spurious_en  = spur;
        task_pending = 1;
        start_cnt    = task_end_cnt;

        @(posedge clk);
        #1;
        exp_len  = LEN_W'(len_in);
        task_req = 1'b1;
        @(posedge clk);
        #1;
        task_req = 1'b0;
        checkOutput("start_busy", int'(busy), 1);
        checkOutput("start_mm_req", int'(bus.mm_req), 1);

        if (dup_req) begin
            repeat (3) @(posedge clk);
            #1;
            exp_len  = LEN_W'($urandom_range(0, 50));
            task_req = 1'b1;
            @(posedge clk);
            #1;
            task_req = 1'b0;
        end

        if (wait_done) begin
            bound = nops * (lat + 4) + 50;
            for (int c = 0; c < bound && task_end_cnt == start_cnt; c++) @(negedge clk);
            repeat (3) @(negedge clk);
            checkOutput("task_end_count", task_end_cnt - start_cnt, 1);
            spurious_en = 0;
        end
    endtask

    task automatic fillRandom();
        for (int a = 0; a < N; a++)
            for (int w = 0; w < K / 32; w++)
                mem[a][w*32 +: 32] = $urandom();
    endtask

    task automatic clearMem();
        for (int a = 0; a < N; a++) mem[a] = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mm_req"}, int'(bus.mm_req), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_task_end"}, int'(task_end), 0);
        checkOutput({tag, "_x_sel"}, int'(bus.mm_x_sel), 0);
        checkOutput({tag, "_y_sel"}, int'(bus.mm_y_sel), 0);
        checkOutput({tag, "_dst_sel"}, int'(bus.mm_dst_sel), 0);
        checkOutput({tag, "_exp_rd_addr"}, int'(bus.exp_rd_addr), 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        rst_n    = 1'b1;
        task_req = 1'b0;
        exp_len  = '0;
        clearMem();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] exp_len=0");
        fillRandom();
        applyStimulus(0, 3, 0, 0, 1);
        checkOutput("addr_stays_zero", int'(bus.exp_rd_addr), 0);

        $display("[TB] exp_len=4, word0=1011");
        fillRandom();
        mem[0][3:0] = 4'b1011;
        applyStimulus(4, 5, 0, 0, 1);

        $display("[TB] exp_len=K+1 across a word boundary");
        fillRandom();
        mem[1][0] = 1'b1;
        mem[0]    = '0;
        applyStimulus(K + 1, 20, 0, 0, 1);

        $display("[TB] single bit and exact word length");
        fillRandom();
        applyStimulus(1, 2, 0, 1, 1);
        applyStimulus(K, 2, 0, 0, 1);

        $display("[TB] randomized tasks");
        for (int t = 0; t < 5; t++) begin
            fillRandom();
            applyStimulus($urandom_range(16, 3 * K), $urandom_range(0, 5), t[0], t >= 2, 1);
        end

        $display("[TB] exp_len above N*K is clamped");
        clearMem();
        mem[N-1][K-1] = 1'b1;
        mem[N-1][0]   = 1'b1;
        mem[5][77]    = 1'b1;
        mem[0][0]     = 1'b1;
        applyStimulus(5000, 1, 0, 0, 1);

        $display("[TB] reset during SQR");
        fillRandom();
        applyStimulus(40, 20, 0, 0, 0);
        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (bus.mm_req && bus.mm_x_sel == 3'(ACC) && bus.mm_y_sel == 3'(ACC)) found = 1;
        end
        checkOutput("sqr_reached", int'(found), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        task_pending = 0;
        #1;
        checkAllZero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fillRandom();
        applyStimulus(20, 4, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmp_modexp_ctrl.md
# mmp_modexp_ctrl

Sequencer that drives one IDDMM Montgomery multiplier through a left-to-right binary modular exponentiation (result = base^e mod m) for the Paillier datapath. It issues one multiplication at a time over a level request/pulse-done handshake. It selects the operand sources and result destination for each multiplication, and streams exponent bits from an external word-addressed memory. It sits between the Paillier top-level task scheduler and the multiplier core with its operand RAMs.

## Interface
- N, 32: multiplier operand length in words
- K, 128: word width in bits; also exponent memory word width
- ADDR_W, $clog2(N): exponent word address width
- LEN_W, $clog2(N*K)+1: exponent length field width (13 at defaults)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- task_req  in  1  start pulse; sampled only in IDLE
- exp_len  in  LEN_W  exponent bit count, 0..N*K; sampled with task_req
- busy  out  1  high from the cycle after accepted task_req until task_end
- task_end  out  1  one-cycle pulse when the result is written
- mm_req  out  1  multiply request; level, held until mm_end
- mm_end  in  1  one-cycle done pulse from the multiplier
- mm_x_sel  out  3  X operand source: 0 BASE, 1 R2, 2 ONE, 3 ACC, 4 XM
- mm_y_sel  out  3  Y operand source, same encoding
- mm_dst_sel  out  2  destination: 0 XM, 1 ACC, 2 RESULT
- exp_rd_addr  out  ADDR_W  exponent word address
- exp_rd_data  in  K  exponent word; read latency of 1 cycle

## Operation
- States: IDLE, PRE_X, PRE_A, FETCH, FWAIT, SQR, MUL, POST, DONE.
- IDLE -> PRE_X on task_req. The block latches exp_len into bit counter b = exp_len.
- PRE_X: mm(BASE, R2) -> XM.
- PRE_A: mm(ONE, R2) -> ACC.
- After PRE_A, the next state depends on b:
  - b == 0 -> POST.
  - otherwise -> FETCH.
- Bit loop, bit index i = b-1, processed MSB first:
  - FETCH: exp_rd_addr = i/K.
  - FWAIT: the block loads exp_rd_data into the bit shift register and aligns it to bit i%K.
  - SQR: mm(ACC, ACC) -> ACC.
  - If bit i is 1: MUL: mm(ACC, XM) -> ACC.
  - Then b decrements.
  - If b == 0 -> POST.
  - Else if the new i%K == K-1 (word boundary) -> FETCH.
  - Else -> SQR.
- POST: mm(ACC, ONE) -> RESULT. Then DONE: task_end pulses, busy drops, return to IDLE.
- Each multiply state has an issue phase and a wait phase:
  - mm_req rises at entry.
  - Select outputs are stable for the whole time mm_req is high.
- exp_len > N*K is clamped to N*K.
- task_req while busy is ignored.
- mm_end while mm_req is low is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - Selects 0.
  - exp_rd_addr 0.
  - State IDLE.
- Reset mid-operation: mm_req drops asynchronously and the task is abandoned. No task_end is issued.
- Start latency: task_req at cycle t -> busy and mm_req (PRE_X) high at t+1.
- Multiply turnaround:
  - mm_end at cycle t -> mm_req low at t+1.
  - The next request rises at t+2 with new selects.
  - mm_req is never high on two consecutive operations without a low cycle between them.
- Word fetch adds 2 cycles: FETCH at t+1, FWAIT at t+2, SQR mm_req at t+3.
- task_end is high on the cycle after the POST mm_end. busy is low from the same cycle.
- mm_end arriving in the same cycle as mm_req rises is legal; the operation completes.
- Total operations = 3 + exp_len + popcount(exponent[exp_len-1:0]).

## Structure
- Package mmp_modexp_pkg holds:
  - the operand-select encodings (SRC_BASE..SRC_XM);
  - the destination encodings (DST_XM, DST_ACC, DST_RESULT);
  - the state enumeration.
- Sub-module mmp_modexp_ebit: exponent bit streamer containing the bit counter, word-address generation, the shift register, and the last-bit and word-boundary flags.
- The FSM and handshake live in the top level.

## Test plan
- exp_len=0 -> exactly 3 ops: PRE_X, PRE_A, POST. No FETCH; exp_rd_addr stays 0. task_end is asserted once.
- exp_len=4, word0=4'b1011 -> 10 ops in order: PRE_X, PRE_A, SQR, MUL, SQR, SQR, MUL, SQR, MUL, POST. ACC, XM and RESULT destinations are correct.
- exp_len=K+1, word1 bit0=1, word0=0 -> fetch at addr 1, then after 1 bit a fetch at addr 0. Ops = 3+(K+1)+1.
- The multiplier model returns mm_end with random latency 0..20 cycles -> selects stay stable while mm_req is high, there is a 1-cycle gap between ops, and there is no lost or extra op.
- task_req pulsed while busy, and a spurious mm_end while mm_req is low -> both ignored and the op sequence is unchanged.
- rst_n asserted during SQR -> all outputs 0 immediately. A new task_req after release runs a full correct sequence.
